// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the seven-segment scan driver.
// Glyphs are active-high: bit SEG_A (0) is segment a, bit SEG_G (6) is segment g.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F_IDX = 5;
  localparam int unsigned SEG_G = 6;

  localparam seg_t SEG_0   = 7'h3F;
  localparam seg_t SEG_1   = 7'h06;
  localparam seg_t SEG_2   = 7'h5B;
  localparam seg_t SEG_3   = 7'h4F;
  localparam seg_t SEG_4   = 7'h66;
  localparam seg_t SEG_5   = 7'h6D;
  localparam seg_t SEG_6   = 7'h7D;
  localparam seg_t SEG_7   = 7'h07;
  localparam seg_t SEG_8   = 7'h7F;
  localparam seg_t SEG_9   = 7'h6F;
  localparam seg_t SEG_HA  = 7'h77;
  localparam seg_t SEG_HB  = 7'h7C;
  localparam seg_t SEG_HC  = 7'h39;
  localparam seg_t SEG_HD  = 7'h5E;
  localparam seg_t SEG_HE  = 7'h79;
  localparam seg_t SEG_HF  = 7'h71;
  localparam seg_t SEG_OFF = 7'h00;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-high seven-segment glyph.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       segs
);

  // Glyph lookup
  always_comb begin
    segs = SEG_OFF;
    case (nibble)
      4'h0: segs = SEG_0;
      4'h1: segs = SEG_1;
      4'h2: segs = SEG_2;
      4'h3: segs = SEG_3;
      4'h4: segs = SEG_4;
      4'h5: segs = SEG_5;
      4'h6: segs = SEG_6;
      4'h7: segs = SEG_7;
      4'h8: segs = SEG_8;
      4'h9: segs = SEG_9;
      4'hA: segs = SEG_HA;
      4'hB: segs = SEG_HB;
      4'hC: segs = SEG_HC;
      4'hD: segs = SEG_HD;
      4'hE: segs = SEG_HE;
      4'hF: segs = SEG_HF;
      default: segs = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous loading,
// per-slot dead time, decimal points and global blanking.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned BLANK_CYCLES   = 500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic                    blank_i,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    frame_done_o
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam seg_t                  SEG_OFF_LVL = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF_LVL  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF_LVL  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, act_val_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q;
  logic                    pend_valid_q;
  logic                    frame_done_q;

  logic [3:0]            nibble;
  seg_t                  glyph;
  logic                  suppress;
  logic [NUM_DIGITS-1:0] an_sel;

  // Divider and digit index next state
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Scan counters; frame_done is registered from next state so it lines up with the last cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      frame_done_q <= (div_d == DIV_LAST) && (idx_d == IDX_LAST);
    end
  end

  // Pending/active double buffer; active only changes at a frame boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      pend_valid_q <= 1'b0;
    end else if (frame_done_q) begin
      if (load_i) begin
        act_val_q <= value_i;
        act_dp_q  <= dp_i;
      end else if (pend_valid_q) begin
        act_val_q <= pend_val_q;
        act_dp_q  <= pend_dp_q;
      end
      pend_valid_q <= 1'b0;
    end else if (load_i) begin
      pend_val_q   <= value_i;
      pend_dp_q    <= dp_i;
      pend_valid_q <= 1'b1;
    end
  end

  assign nibble = act_val_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decoder u_hex_decoder (
    .nibble (nibble),
    .segs   (glyph)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask;

  // Walk down from the top digit; a digit is hidden while everything above it is zero
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run   = zero_run && (act_val_q[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_run && (k != 0) && !act_dp_q[k];
    end
  end

  assign suppress = lz_mask[idx_q];
`else
  assign suppress = 1'b0;
`endif

  // One-hot select of the current digit
  always_comb begin
    an_sel        = '0;
    an_sel[idx_q] = 1'b1;
  end

  // Registered pin drive with polarity applied here only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      segments <= SEG_OFF_LVL;
      dp       <= DP_OFF_LVL;
      anodes   <= AN_OFF_LVL;
    end else if (blank_i) begin
      segments <= SEG_OFF_LVL;
      dp       <= DP_OFF_LVL;
      anodes   <= AN_OFF_LVL;
    end else begin
      segments <= SEG_ACTIVE_LOW ? ~glyph : glyph;
      dp       <= SEG_ACTIVE_LOW ? ~act_dp_q[idx_q] : act_dp_q[idx_q];
      if ((div_q < BLANK_END) || suppress) begin
        anodes <= AN_OFF_LVL;
      end else begin
        anodes <= AN_ACTIVE_LOW ? ~an_sel : an_sel;
      end
    end
  end

  assign frame_done_o = frame_done_q;

endmodule
